// File: rtl/leak_pkg.sv
// Shared definitions for the leakage-load serializer: width defaults, FSM states
// and the saturating counter helper.
package leak_pkg;

  localparam int LOAD_W_DEF  = 64;
  localparam int SLICE_W_DEF = 8;
  localparam int CNT_W       = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } leak_state_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] r;
    if (v == {CNT_W{1'b1}}) begin
      r = v;
    end else begin
      r = v + CNT_W'(1);
    end
    return r;
  endfunction

endpackage

// File: rtl/leak_word_fifo.sv
// Synchronous word FIFO with fall-through head; push/pop are guarded against
// full/empty so the pointers can never run past each other.
module leak_word_fifo
  import leak_pkg::*;
#(
  parameter int WIDTH = LOAD_W_DEF,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [LVL_W-1:0] level_r;
  logic             push_s;
  logic             pop_s;

  assign full   = (level_r == LVL_W'(DEPTH));
  assign empty  = (level_r == {LVL_W{1'b0}});
  assign push_s = push & ~full;
  assign pop_s  = pop & ~empty;
  assign dout   = mem_r[rd_ptr_r];
  assign level  = level_r;

  // Storage array; data needs no reset since level gates every read.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      level_r  <= {LVL_W{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   level_r <= level_r + LVL_W'(1);
        2'b01:   level_r <= level_r - LVL_W'(1);
        default: level_r <= level_r;
      endcase
    end
  end

endmodule

// File: rtl/leak_load_serializer.sv
// Buffers 64-bit leakage load words and streams them out LSB slice first as
// SLICE_W-bit valid/ready beats, with a forced idle gap between frames.
module leak_load_serializer
  import leak_pkg::*;
#(
  parameter int LOAD_W     = LOAD_W_DEF,
  parameter int SLICE_W    = SLICE_W_DEF,
  parameter int FIFO_DEPTH = 4,
  parameter int IDLE_GAP   = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [LOAD_W-1:0]             load_in,
  input  logic                          load_valid,
  input  logic                          en,
  output logic [SLICE_W-1:0]            tx_data,
  output logic                          tx_valid,
  output logic                          tx_last,
  input  logic                          tx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [15:0]                   frame_cnt,
  output logic [15:0]                   drop_cnt
);

  localparam int BEATS    = LOAD_W / SLICE_W;
  localparam int BEAT_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int GAP_W    = (IDLE_GAP > 1) ? $clog2(IDLE_GAP) : 1;
  localparam int GAP_LAST = (IDLE_GAP > 0) ? IDLE_GAP - 1 : 0;
  localparam logic [BEAT_W-1:0] BEAT_END = BEAT_W'(BEATS - 1);
  localparam logic [GAP_W-1:0]  GAP_END  = GAP_W'(GAP_LAST);

  leak_state_e         state_r,     state_n;
  logic [LOAD_W-1:0]   shreg_r,     shreg_n;
  logic [BEAT_W-1:0]   beat_idx_r,  beat_idx_n;
  logic [GAP_W-1:0]    gap_cnt_r,   gap_cnt_n;
  logic                tx_valid_r,  tx_valid_n;
  logic                tx_last_r,   tx_last_n;
  logic [CNT_W-1:0]    frame_cnt_r, frame_cnt_n;
  logic [CNT_W-1:0]    drop_cnt_r,  drop_cnt_n;

  logic                fifo_full_s;
  logic                fifo_empty_s;
  logic [LOAD_W-1:0]   fifo_dout_s;
  logic                push_s;
  logic                drop_s;
  logic                pop_s;

  // Fullness is taken before any same-cycle pop, so a full FIFO always drops.
  assign push_s = load_valid & ~fifo_full_s;
  assign drop_s = load_valid & fifo_full_s;

  leak_word_fifo #(
    .WIDTH (LOAD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .din   (load_in),
    .pop   (pop_s),
    .dout  (fifo_dout_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .level (fifo_level)
  );

  assign tx_data   = shreg_r[SLICE_W-1:0];
  assign tx_valid  = tx_valid_r;
  assign tx_last   = tx_last_r;
  assign frame_cnt = frame_cnt_r;
  assign drop_cnt  = drop_cnt_r;

  // Next-state, datapath and pop decision for the frame FSM.
  always_comb begin
    state_n     = state_r;
    shreg_n     = shreg_r;
    beat_idx_n  = beat_idx_r;
    gap_cnt_n   = gap_cnt_r;
    tx_valid_n  = tx_valid_r;
    tx_last_n   = tx_last_r;
    frame_cnt_n = frame_cnt_r;
    pop_s       = 1'b0;

    if (drop_s) begin
      drop_cnt_n = sat_inc(drop_cnt_r);
    end else begin
      drop_cnt_n = drop_cnt_r;
    end

    case (state_r)
      IDLE: begin
        if (en && !fifo_empty_s) begin
          pop_s      = 1'b1;
          shreg_n    = fifo_dout_s;
          beat_idx_n = {BEAT_W{1'b0}};
          tx_valid_n = 1'b1;
          tx_last_n  = (BEAT_END == {BEAT_W{1'b0}});
          state_n    = SHIFT;
        end else begin
          state_n    = IDLE;
        end
      end
      SHIFT: begin
        if (tx_valid_r && tx_ready) begin
          if (beat_idx_r == BEAT_END) begin
            frame_cnt_n = frame_cnt_r + CNT_W'(1);
            tx_valid_n  = 1'b0;
            tx_last_n   = 1'b0;
            gap_cnt_n   = {GAP_W{1'b0}};
            state_n     = (IDLE_GAP > 0) ? GAP : IDLE;
          end else begin
            shreg_n     = shreg_r >> SLICE_W;
            beat_idx_n  = beat_idx_r + BEAT_W'(1);
            tx_last_n   = ((beat_idx_r + BEAT_W'(1)) == BEAT_END);
          end
        end else begin
          state_n = SHIFT;
        end
      end
      GAP: begin
        if (gap_cnt_r == GAP_END) begin
          state_n   = IDLE;
        end else begin
          gap_cnt_n = gap_cnt_r + GAP_W'(1);
        end
      end
      default: begin
        state_n    = IDLE;
        tx_valid_n = 1'b0;
        tx_last_n  = 1'b0;
      end
    endcase
  end

  // FSM and datapath registers; reset abandons any frame in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      shreg_r     <= {LOAD_W{1'b0}};
      beat_idx_r  <= {BEAT_W{1'b0}};
      gap_cnt_r   <= {GAP_W{1'b0}};
      tx_valid_r  <= 1'b0;
      tx_last_r   <= 1'b0;
      frame_cnt_r <= {CNT_W{1'b0}};
      drop_cnt_r  <= {CNT_W{1'b0}};
    end else begin
      state_r     <= state_n;
      shreg_r     <= shreg_n;
      beat_idx_r  <= beat_idx_n;
      gap_cnt_r   <= gap_cnt_n;
      tx_valid_r  <= tx_valid_n;
      tx_last_r   <= tx_last_n;
      frame_cnt_r <= frame_cnt_n;
      drop_cnt_r  <= drop_cnt_n;
    end
  end

endmodule
